jts16_bank_arb: RTL and testbench
=================================

JTS16_BANK_ARB -- requirements
Module: jts16_bank_arb

Interface
REQ-001 Parameter RFSH_CNT, default 8'd64: clock cycles between refresh requests while refresh_en is high.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port list, one per line as name, direction, width, meaning:
- rst  in  1  synchronous reset, active-high
- clk  in  1  single clock
- ba0_addr  in  22  bank0 word address
- ba0_rd  in  1  bank0 read request
- ba0_wr  in  1  bank0 write request
- ba0_din  in  16  bank0 write data
- ba0_din_m  in  2  bank0 write mask, active-high byte disable
- ba1_addr, ba2_addr, ba3_addr  in  22 each  bank1-3 addresses
- ba1_rd, ba2_rd, ba3_rd  in  1 each  bank1-3 read requests
- ba0_ack .. ba3_ack  out  1 each  request accepted, one-cycle pulse
- ba0_rdy .. ba3_rdy  out  1 each  data valid or write done, one-cycle pulse
- data_read  out  32  read data shared by all banks
- refresh_en  in  1  refresh allowed (blanking)
- sdr_req  out  1  command request to SDRAM core
- sdr_ba  out  2  bank of command
- sdr_addr  out  22  command address
- sdr_we  out  1  1 = write, 0 = read
- sdr_din  out  16  write data
- sdr_mask  out  2  write mask
- sdr_rfsh  out  1  refresh request
- sdr_gnt  in  1  core accepted current request or refresh
- sdr_dok  in  1  core finished data phase
- sdr_dout  in  32  core read data

Function
REQ-004 FSM states: IDLE, CMD, DATA, RFSH.
REQ-005 IDLE behaviour:
- refresh pending -> RFSH, with priority over all banks.
- else any request -> CMD.
- A bank requests when baN_rd is high; bank0 also requests when ba0_wr is high.
REQ-006 Round-robin arbitration: the search starts at the bank after the last granted bank. Reset value of the last granted bank is 3, so bank0 wins first.
REQ-007 Latching on leaving IDLE: sdr_ba, sdr_addr, sdr_we, sdr_din and sdr_mask are latched. They stay stable until the next IDLE exit.
REQ-008 Bank0 with rd and wr both high is a write. Banks 1-3 always issue sdr_we = 0.
REQ-009 CMD: sdr_req stays high until sdr_gnt is sampled high. In that cycle the FSM drops sdr_req, pulses baN_ack for the latched bank only, and moves to DATA.
REQ-010 DATA: on sdr_dok the FSM registers sdr_dout into data_read, pulses baN_rdy one cycle later (aligned with the new data_read), and returns to IDLE.
- For writes, data_read is left unchanged.
- rdy is still pulsed.
REQ-011 Minimum turnaround: request seen in IDLE -> sdr_req high the next cycle. A new command can be issued at the earliest two cycles after sdr_dok.
REQ-012 Requests that drop after leaving IDLE do not cancel the transaction. Latched values are used and ack/rdy are still pulsed.
REQ-013 A request that stays high after its rdy is treated as a new request, subject to round-robin.
REQ-014 Refresh counter, 8 bits:
- Increments each cycle while refresh_en is high.
- Holds while refresh_en is low.
- On reaching RFSH_CNT-1 it sets the pending flag and wraps to 0.
- A second expiry while already pending is absorbed (flag stays 1, no queue).
REQ-015 RFSH: sdr_rfsh stays high until sdr_gnt, then the pending flag clears and the FSM returns to IDLE. No ack/rdy pulse is produced and no data phase occurs.
REQ-016 sdr_gnt or sdr_dok arriving in a state that does not expect it is ignored.
REQ-017 At most one baN_ack and one baN_rdy are high in any cycle, and never for a bank other than the latched one.

Reset
REQ-018 Reset values:
- All ack and rdy outputs 0.
- sdr_req = 0, sdr_rfsh = 0, sdr_we = 0.
- sdr_ba, sdr_addr, sdr_din, sdr_mask and data_read all 0.
- FSM in IDLE, refresh counter and pending flag 0, last granted bank = 3.
REQ-019 Reset asserted mid-transaction (CMD, DATA or RFSH) forces the reset values on the next edge and drops any outstanding transaction with no ack/rdy pulse. The bench keeps sdr_gnt/sdr_dok low after reset until a new request.

Verification
REQ-020 Single read: ba2_rd=1, ba2_addr=22'h12345, sdr_gnt 2 cycles later, sdr_dok with sdr_dout=32'hDEADBEEF 3 cycles after that. Required:
- sdr_ba=2 and sdr_addr=22'h12345.
- ba2_ack pulses once, then ba2_rdy pulses once with data_read=32'hDEADBEEF.
REQ-021 Round robin: ba0_rd..ba3_rd all held high with immediate gnt/dok. Required grant order 0,1,2,3,0; ack pulses follow the same order.
REQ-022 Write: ba0_wr=1, ba0_rd=1, ba0_din=16'hA55A, ba0_din_m=2'b01. Required:
- sdr_we=1, sdr_din=16'hA55A, sdr_mask=2'b01.
- ba0_rdy pulses and data_read is unchanged.
REQ-023 Refresh: RFSH_CNT=4, refresh_en=1 and ba1_rd=1 held. Required:
- Pending sets after 4 cycles.
- The next IDLE issues sdr_rfsh before any further ba1 command.
- With refresh_en=0 the counter freezes and no sdr_rfsh occurs.
REQ-024 Reset in DATA: rst=1 one cycle while awaiting sdr_dok. Required:
- All outputs return to reset values.
- No rdy pulse occurs.
- The next ba3_rd is served normally with ack and rdy.

Source files
------------

// File: rtl/jts16_bank_arb.sv
// ---------------------------------------------------------------------------
// jts16_bank_arb
//
// Purpose:
//   Arbitrates four request banks onto a single SDRAM core command port and
//   inserts periodic refresh cycles. Bank0 can read or write. Banks 1-3 are
//   read-only. Banks are served round-robin. A pending refresh always takes
//   priority over bank traffic when the arbiter is idle.
//
// Parameters:
//   RFSH_CNT    clock cycles between refresh requests while refresh_en is high
//
// Ports:
//   rst, clk                 synchronous active-high reset, single clock
//   ba0_addr/rd/wr/din/din_m bank0 request (address, read, write, data, mask)
//   ba1..3_addr, ba1..3_rd   bank1-3 read requests
//   ba0..3_ack               one-cycle pulse when the core accepts a command
//   ba0..3_rdy               one-cycle pulse when read data is valid or a
//                            write has completed
//   data_read                last read data, shared by all banks
//   refresh_en               refresh counting allowed (blanking period)
//   sdr_req/ba/addr/we/din/mask  command to the SDRAM core
//   sdr_rfsh                 refresh request to the SDRAM core
//   sdr_gnt                  core accepted the current command or refresh
//   sdr_dok                  core finished the data phase
//   sdr_dout                 core read data
// ---------------------------------------------------------------------------
module jts16_bank_arb #(
  parameter logic [7:0] RFSH_CNT = 8'd64
) (
  input  logic        rst,
  input  logic        clk,

  input  logic [21:0] ba0_addr,
  input  logic        ba0_rd,
  input  logic        ba0_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,

  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic        ba1_rd,
  input  logic        ba2_rd,
  input  logic        ba3_rd,

  output logic        ba0_ack,
  output logic        ba1_ack,
  output logic        ba2_ack,
  output logic        ba3_ack,
  output logic        ba0_rdy,
  output logic        ba1_rdy,
  output logic        ba2_rdy,
  output logic        ba3_rdy,
  output logic [31:0] data_read,

  input  logic        refresh_en,

  output logic        sdr_req,
  output logic [1:0]  sdr_ba,
  output logic [21:0] sdr_addr,
  output logic        sdr_we,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_mask,
  output logic        sdr_rfsh,
  input  logic        sdr_gnt,
  input  logic        sdr_dok,
  input  logic [31:0] sdr_dout
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    RFSH
  } state_t;

  state_t      state;
  logic [1:0]  last;
  logic [3:0]  ack;
  logic [3:0]  rdy;
  logic [3:0]  req;
  logic [1:0]  win;
  logic [21:0] win_addr;
  logic [7:0]  rfsh_cnt;
  logic        rfsh_pend;
  logic        rfsh_done;

  // Bank0 requests on either read or write; the others only read.
  assign req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};

  // Round-robin pick: the bank closest after 'l' (wrapping) that requests.
  // Walking from the farthest candidate to the nearest lets the nearest
  // one overwrite the result, so no early exit is needed.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
    pick = l;
    for (int i = 4; i >= 1; i--) begin
      c = l + 2'(i);
      if (r[c]) pick = c;
    end
  endfunction

  assign win = pick(req, last);

  // Address of the winning bank, latched when the command is issued.
  always_comb begin
    win_addr = ba0_addr;
    case (win)
      2'd0:    win_addr = ba0_addr;
      2'd1:    win_addr = ba1_addr;
      2'd2:    win_addr = ba2_addr;
      default: win_addr = ba3_addr;
    endcase
  end

  assign rfsh_done = (state == RFSH) && sdr_gnt;

  // Refresh timer. Counts only while refresh is allowed. An expiry while a
  // refresh is already pending just keeps the flag set. If an expiry lands
  // on the cycle the previous refresh is granted, the new expiry wins so no
  // refresh slot is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rfsh_cnt  <= 8'd0;
      rfsh_pend <= 1'b0;
    end else begin
      if (rfsh_done) rfsh_pend <= 1'b0;
      if (refresh_en) begin
        if (rfsh_cnt == RFSH_CNT - 8'd1) begin
          rfsh_cnt  <= 8'd0;
          rfsh_pend <= 1'b1;
        end else begin
          rfsh_cnt <= rfsh_cnt + 8'd1;
        end
      end
    end
  end

  // Main arbiter FSM. All command fields are latched on leaving IDLE and
  // stay put until the next IDLE exit, so requesters may drop their
  // request right after it has been seen. ack/rdy are cleared every cycle
  // and set only for the latched bank, making them single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      ack       <= 4'd0;
      rdy       <= 4'd0;
      data_read <= 32'd0;
      sdr_req   <= 1'b0;
      sdr_ba    <= 2'd0;
      sdr_addr  <= 22'd0;
      sdr_we    <= 1'b0;
      sdr_din   <= 16'd0;
      sdr_mask  <= 2'd0;
      sdr_rfsh  <= 1'b0;
    end else begin
      ack <= 4'd0;
      rdy <= 4'd0;
      case (state)
        IDLE: begin
          if (rfsh_pend) begin
            sdr_rfsh <= 1'b1;
            state    <= RFSH;
          end else if (|req) begin
            sdr_req  <= 1'b1;
            sdr_ba   <= win;
            sdr_addr <= win_addr;
            sdr_we   <= (win == 2'd0) && ba0_wr;
            sdr_din  <= (win == 2'd0) ? ba0_din : 16'd0;
            sdr_mask <= (win == 2'd0) ? ba0_din_m : 2'd0;
            last     <= win;
            state    <= CMD;
          end
        end
        CMD: begin
          if (sdr_gnt) begin
            sdr_req     <= 1'b0;
            ack[sdr_ba] <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (sdr_dok) begin
            if (!sdr_we) data_read <= sdr_dout;
            rdy[sdr_ba] <= 1'b1;
            state       <= IDLE;
          end
        end
        RFSH: begin
          if (sdr_gnt) begin
            sdr_rfsh <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack;
  assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy;

endmodule

// File: tb/tb_jts16_bank_arb.sv
// ---------------------------------------------------------------------------
// tb_jts16_bank_arb
//
// Purpose:
//   Directed self-checking bench for jts16_bank_arb (built with RFSH_CNT=4).
//   Covers reset values, round-robin order, a single read, a bank0 write,
//   refresh timing/freeze/priority and reset during a data phase. A passive
//   monitor counts ack/rdy pulses and flags multi-hot or wrong-bank pulses.
// ---------------------------------------------------------------------------
module tb_jts16_bank_arb;

  logic        rst = 1'b1;
  logic        clk = 1'b0;
  logic [21:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
  logic        ba0_rd = 1'b0, ba0_wr = 1'b0, ba1_rd = 1'b0, ba2_rd = 1'b0, ba3_rd = 1'b0;
  logic [15:0] ba0_din = '0;
  logic [1:0]  ba0_din_m = '0;
  logic        ba0_ack, ba1_ack, ba2_ack, ba3_ack;
  logic        ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy;
  logic [31:0] data_read;
  logic        refresh_en = 1'b0;
  logic        sdr_req;
  logic [1:0]  sdr_ba;
  logic [21:0] sdr_addr;
  logic        sdr_we;
  logic [15:0] sdr_din;
  logic [1:0]  sdr_mask;
  logic        sdr_rfsh;
  logic        sdr_gnt = 1'b0;
  logic        sdr_dok = 1'b0;
  logic [31:0] sdr_dout = '0;

  logic [3:0]  ack_v, rdy_v;
  assign ack_v = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
  assign rdy_v = {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

  int errors = 0;
  int checks = 0;
  int ack_cnt [4] = '{default: 0};
  int rdy_cnt [4] = '{default: 0};
  int bad_cnt = 0;

  jts16_bank_arb #(.RFSH_CNT(8'd4)) dut (
    .rst        (rst),
    .clk        (clk),
    .ba0_addr   (ba0_addr),
    .ba0_rd     (ba0_rd),
    .ba0_wr     (ba0_wr),
    .ba0_din    (ba0_din),
    .ba0_din_m  (ba0_din_m),
    .ba1_addr   (ba1_addr),
    .ba2_addr   (ba2_addr),
    .ba3_addr   (ba3_addr),
    .ba1_rd     (ba1_rd),
    .ba2_rd     (ba2_rd),
    .ba3_rd     (ba3_rd),
    .ba0_ack    (ba0_ack),
    .ba1_ack    (ba1_ack),
    .ba2_ack    (ba2_ack),
    .ba3_ack    (ba3_ack),
    .ba0_rdy    (ba0_rdy),
    .ba1_rdy    (ba1_rdy),
    .ba2_rdy    (ba2_rdy),
    .ba3_rdy    (ba3_rdy),
    .data_read  (data_read),
    .refresh_en (refresh_en),
    .sdr_req    (sdr_req),
    .sdr_ba     (sdr_ba),
    .sdr_addr   (sdr_addr),
    .sdr_we     (sdr_we),
    .sdr_din    (sdr_din),
    .sdr_mask   (sdr_mask),
    .sdr_rfsh   (sdr_rfsh),
    .sdr_gnt    (sdr_gnt),
    .sdr_dok    (sdr_dok),
    .sdr_dout   (sdr_dout)
  );

  always #5 clk = ~clk;

  // Passive pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (ack_v[i]) ack_cnt[i]++;
        if (rdy_v[i]) rdy_cnt[i]++;
      end
      if ($countones(ack_v) > 1 || $countones(rdy_v) > 1) bad_cnt++;
      if (ack_v != 4'd0 && ack_v != (4'b0001 << sdr_ba)) bad_cnt++;
      if (rdy_v != 4'd0 && rdy_v != (4'b0001 << sdr_ba)) bad_cnt++;
    end
  end

  // Safety net in case the flow below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_ack"},   32'(ack_v),     32'd0);
    checkOutput({pfx, "_rdy"},   32'(rdy_v),     32'd0);
    checkOutput({pfx, "_req"},   32'(sdr_req),   32'd0);
    checkOutput({pfx, "_rfsh"},  32'(sdr_rfsh),  32'd0);
    checkOutput({pfx, "_we"},    32'(sdr_we),    32'd0);
    checkOutput({pfx, "_ba"},    32'(sdr_ba),    32'd0);
    checkOutput({pfx, "_addr"},  32'(sdr_addr),  32'd0);
    checkOutput({pfx, "_din"},   32'(sdr_din),   32'd0);
    checkOutput({pfx, "_mask"},  32'(sdr_mask),  32'd0);
    checkOutput({pfx, "_data"},  data_read,      32'd0);
  endtask

  function automatic int bankOf(input logic [3:0] v);
    bankOf = 99;
    for (int i = 3; i >= 0; i--) if (v[i]) bankOf = i;
  endfunction

  initial begin
    int order[$];
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int a_before, r_before, rf_seen;

    // Reset
    waitCycles(2);
    checkResetValues("reset");
    rst = 1'b0;
    waitCycles(1);

    // Round robin with immediate grant / done
    $display("[TB] round robin");
    {ba3_rd, ba2_rd, ba1_rd, ba0_rd} = 4'b1111;
    sdr_gnt = 1'b1;
    sdr_dok = 1'b1;
    for (int i = 0; i < 40 && order.size() < 5; i++) begin
      waitCycles(1);
      if (ack_v != 4'd0) order.push_back(bankOf(ack_v));
    end
    {ba3_rd, ba2_rd, ba1_rd, ba0_rd} = 4'b0000;
    waitCycles(1);
    sdr_gnt = 1'b0;
    sdr_dok = 1'b0;
    waitCycles(1);
    checkOutput("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("rr_grant%0d", i),
                  32'((i < order.size()) ? order[i] : 99), 32'(rr_exp[i]));

    // Single read on bank2
    $display("[TB] single read");
    a_before = ack_cnt[2];
    r_before = rdy_cnt[2];
    ba2_addr = 22'h12345;
    ba2_rd   = 1'b1;
    waitCycles(1);
    checkOutput("rd_req",  32'(sdr_req),  32'd1);
    checkOutput("rd_ba",   32'(sdr_ba),   32'd2);
    checkOutput("rd_addr", 32'(sdr_addr), 32'h12345);
    checkOutput("rd_we",   32'(sdr_we),   32'd0);
    ba2_rd = 1'b0;
    waitCycles(1);
    checkOutput("rd_req_hold", 32'(sdr_req), 32'd1);
    checkOutput("rd_no_ack",   32'(ack_v),   32'd0);
    sdr_gnt = 1'b1;
    waitCycles(1);
    checkOutput("rd_ack",     32'(ack_v),   32'b0100);
    checkOutput("rd_req_off", 32'(sdr_req), 32'd0);
    sdr_gnt = 1'b0;
    waitCycles(2);
    checkOutput("rd_ack_once", 32'(ack_v), 32'd0);
    checkOutput("rd_no_rdy",   32'(rdy_v), 32'd0);
    sdr_dok  = 1'b1;
    sdr_dout = 32'hDEADBEEF;
    waitCycles(1);
    checkOutput("rd_rdy",  32'(rdy_v), 32'b0100);
    checkOutput("rd_data", data_read,  32'hDEADBEEF);
    sdr_dok = 1'b0;
    waitCycles(1);
    checkOutput("rd_rdy_off", 32'(rdy_v),   32'd0);
    checkOutput("rd_idle",    32'(sdr_req), 32'd0);
    checkOutput("rd_ack_cnt", 32'(ack_cnt[2] - a_before), 32'd1);
    checkOutput("rd_rdy_cnt", 32'(rdy_cnt[2] - r_before), 32'd1);

    // Bank0 write (rd and wr both high)
    $display("[TB] write");
    sdr_dout  = 32'h11112222;
    ba0_addr  = 22'h00ABC;
    ba0_din   = 16'hA55A;
    ba0_din_m = 2'b01;
    ba0_wr    = 1'b1;
    ba0_rd    = 1'b1;
    waitCycles(1);
    checkOutput("wr_ba",   32'(sdr_ba),   32'd0);
    checkOutput("wr_we",   32'(sdr_we),   32'd1);
    checkOutput("wr_din",  32'(sdr_din),  32'hA55A);
    checkOutput("wr_mask", 32'(sdr_mask), 32'b01);
    ba0_wr    = 1'b0;
    ba0_rd    = 1'b0;
    ba0_din   = 16'h0000;
    ba0_din_m = 2'b00;
    sdr_gnt   = 1'b1;
    waitCycles(1);
    checkOutput("wr_ack",       32'(ack_v),   32'b0001);
    checkOutput("wr_din_latch", 32'(sdr_din), 32'hA55A);
    sdr_gnt = 1'b0;
    sdr_dok = 1'b1;
    waitCycles(1);
    checkOutput("wr_rdy",  32'(rdy_v), 32'b0001);
    checkOutput("wr_data", data_read,  32'hDEADBEEF);
    sdr_dok = 1'b0;
    waitCycles(1);

    // Refresh: timing and freeze while refresh_en is low
    $display("[TB] refresh");
    refresh_en = 1'b1;
    waitCycles(2);
    refresh_en = 1'b0;
    rf_seen = 0;
    for (int i = 0; i < 10; i++) begin
      waitCycles(1);
      if (sdr_rfsh) rf_seen++;
    end
    checkOutput("rf_frozen", 32'(rf_seen), 32'd0);
    refresh_en = 1'b1;
    waitCycles(2);
    checkOutput("rf_not_yet", 32'(sdr_rfsh), 32'd0);
    waitCycles(1);
    checkOutput("rf_issue", 32'(sdr_rfsh), 32'd1);
    refresh_en = 1'b0;
    ba1_addr   = 22'h00777;
    ba1_rd     = 1'b1;
    waitCycles(2);
    checkOutput("rf_hold",   32'(sdr_rfsh), 32'd1);
    checkOutput("rf_no_req", 32'(sdr_req),  32'd0);
    sdr_gnt = 1'b1;
    waitCycles(1);
    checkOutput("rf_drop",   32'(sdr_rfsh), 32'd0);
    checkOutput("rf_no_ack", 32'(ack_v),    32'd0);
    sdr_gnt = 1'b0;
    waitCycles(1);
    checkOutput("rf_cleared", 32'(sdr_rfsh), 32'd0);
    checkOutput("rf_b1_req",  32'(sdr_req),  32'd1);
    checkOutput("rf_b1_ba",   32'(sdr_ba),   32'd1);
    checkOutput("rf_no_rdy",  32'(rdy_v),    32'd0);

    // Refresh priority over a held bank1 request
    refresh_en = 1'b1;
    sdr_gnt    = 1'b1;
    waitCycles(1);
    checkOutput("rp_ack", 32'(ack_v), 32'b0010);
    sdr_gnt = 1'b0;
    waitCycles(3);
    sdr_dok = 1'b1;
    waitCycles(1);
    checkOutput("rp_rdy", 32'(rdy_v), 32'b0010);
    sdr_dok    = 1'b0;
    refresh_en = 1'b0;
    waitCycles(1);
    checkOutput("rp_rfsh",   32'(sdr_rfsh), 32'd1);
    checkOutput("rp_no_req", 32'(sdr_req),  32'd0);
    sdr_gnt = 1'b1;
    waitCycles(1);
    sdr_gnt = 1'b0;
    waitCycles(1);
    checkOutput("rp_b1_after", 32'(sdr_req), 32'd1);
    ba1_rd  = 1'b0;
    sdr_gnt = 1'b1;
    waitCycles(1);
    sdr_gnt = 1'b0;
    sdr_dok = 1'b1;
    waitCycles(1);
    sdr_dok = 1'b0;
    waitCycles(1);

    // Reset while waiting in the data phase
    $display("[TB] reset in data phase");
    ba3_addr = 22'h2AAAA;
    ba3_rd   = 1'b1;
    waitCycles(1);
    checkOutput("rs_ba", 32'(sdr_ba), 32'd3);
    ba3_rd  = 1'b0;
    sdr_gnt = 1'b1;
    waitCycles(1);
    checkOutput("rs_ack", 32'(ack_v), 32'b1000);
    sdr_gnt = 1'b0;
    waitCycles(1);
    r_before = rdy_cnt[3];
    rst = 1'b1;
    waitCycles(1);
    checkResetValues("rs");
    rst = 1'b0;
    waitCycles(3);
    checkOutput("rs_no_rdy", 32'(rdy_cnt[3] - r_before), 32'd0);
    checkOutput("rs_idle",   32'(sdr_req), 32'd0);
    ba3_addr = 22'h3ABCD;
    ba3_rd   = 1'b1;
    waitCycles(1);
    checkOutput("rs2_req",  32'(sdr_req),  32'd1);
    checkOutput("rs2_ba",   32'(sdr_ba),   32'd3);
    checkOutput("rs2_addr", 32'(sdr_addr), 32'h3ABCD);
    ba3_rd  = 1'b0;
    sdr_gnt = 1'b1;
    waitCycles(1);
    checkOutput("rs2_ack", 32'(ack_v), 32'b1000);
    sdr_gnt  = 1'b0;
    sdr_dok  = 1'b1;
    sdr_dout = 32'hCAFEF00D;
    waitCycles(1);
    checkOutput("rs2_rdy",  32'(rdy_v), 32'b1000);
    checkOutput("rs2_data", data_read,  32'hCAFEF00D);
    sdr_dok = 1'b0;
    waitCycles(2);

    checkOutput("pulse_bank", 32'(bad_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
